// File: rtl/corelet_seq_pkg.sv
// Shared definitions for the corelet sequencer and its bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package corelet_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_EXEC,
        S_FLUSH,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    // Corelet instruction bus layout
    localparam int INST_W       = 35;
    localparam int BIT_KLOAD    = 0;
    localparam int BIT_EXEC     = 1;
    localparam int BIT_L0_WR    = 2;
    localparam int BIT_L0_RD    = 3;
    localparam int BIT_OFIFO_RD = 6;
    localparam int BIT_SFP_ACC  = 33;
    localparam int BIT_MODE     = 34;

    // Dataflow mode encoding
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter with enable; zero flag marks the final count of a phase.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; enable is the caller's qualifier and the count saturates at zero.
module seq_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/corelet_seq.sv
// Corelet job sequencer: kernel load, execute, pipeline flush and OFIFO drain per pass.
// Latency: every output is registered, so a command appears the cycle after its qualifying input.
// Backpressure: l0_ready=0 stalls KLOAD/EXEC, ofifo_valid=0 stalls DRAIN; abort/reset force IDLE.
module corelet_seq
    import corelet_seq_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int tile_bw = 5,
    parameter int vec_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [tile_bw-1:0] n_tile,
    input  logic [vec_bw-1:0]  n_vec,
    input  logic               abort,
    input  logic               l0_ready,
    input  logic               ofifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [tile_bw-1:0] pass_idx
);

    // One extra bit so a full-range n_vec never wraps the phase count.
    localparam int CW = vec_bw + 1;

    state_t              state, state_nx;
    logic                mode_q, mode_nx;
    logic [tile_bw-1:0]  ntile_q, ntile_nx;
    logic [vec_bw-1:0]   nvec_q, nvec_nx;
    logic [tile_bw-1:0]  pass_q, pass_nx;
    logic [INST_W-1:0]   inst_nx;
    logic                busy_nx, done_nx, err_nx;

    logic                ke_load, ke_en, ke_zero;
    logic [CW-1:0]       ke_val;
    logic                fl_load, fl_en, fl_zero;
    logic                dr_load, dr_en, dr_zero;
    logic [CW-1:0]       dr_val;

    // Counters are loaded with (count-1) so zero flags the last cycle of a phase.
    function automatic logic [CW-1:0] vec_m1(input logic [vec_bw-1:0] v);
        return {1'b0, v} - CW'(1);
    endfunction

    seq_cnt #(.W(CW)) u_cnt_ke (
        .clk      (clk),
        .reset    (reset),
        .load     (ke_load),
        .load_val (ke_val),
        .en       (ke_en),
        .zero     (ke_zero)
    );

    seq_cnt #(.W(CW)) u_cnt_fl (
        .clk      (clk),
        .reset    (reset),
        .load     (fl_load),
        .load_val (CW'(row + col - 2)),
        .en       (fl_en),
        .zero     (fl_zero)
    );

    seq_cnt #(.W(CW)) u_cnt_dr (
        .clk      (clk),
        .reset    (reset),
        .load     (dr_load),
        .load_val (dr_val),
        .en       (dr_en),
        .zero     (dr_zero)
    );

    // Next state, next registered outputs and counter controls.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        ntile_nx = ntile_q;
        nvec_nx  = nvec_q;
        pass_nx  = pass_q;
        inst_nx  = '0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        ke_load  = 1'b0;
        ke_val   = '0;
        ke_en    = 1'b0;
        fl_load  = 1'b0;
        fl_en    = 1'b0;
        dr_load  = 1'b0;
        dr_val   = '0;
        dr_en    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nx  = mode;
                    ntile_nx = n_tile;
                    nvec_nx  = n_vec;
                    pass_nx  = '0;
                    if ((n_tile == '0) || (n_vec == '0)) begin
                        state_nx = S_DONE;
                        err_nx   = 1'b1;
                    end else begin
                        ke_load = 1'b1;
                        if (mode == MODE_WS) begin
                            state_nx = S_KLOAD;
                            ke_val   = CW'(col - 1);
                        end else begin
                            state_nx = S_EXEC;
                            ke_val   = vec_m1(n_vec);
                        end
                    end
                end
            end
            S_KLOAD: begin
                if (l0_ready) begin
                    inst_nx[BIT_L0_RD] = 1'b1;
                    inst_nx[BIT_KLOAD] = 1'b1;
                    if (ke_zero) begin
                        state_nx = S_EXEC;
                        ke_load  = 1'b1;
                        ke_val   = vec_m1(nvec_q);
                    end else begin
                        ke_en = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (l0_ready) begin
                    inst_nx[BIT_L0_RD] = 1'b1;
                    inst_nx[BIT_EXEC]  = 1'b1;
                    if (ke_zero) begin
                        state_nx = S_FLUSH;
                        fl_load  = 1'b1;
                    end else begin
                        ke_en = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (fl_zero) begin
                    state_nx = S_DRAIN;
                    dr_load  = 1'b1;
                    dr_val   = (mode_q == MODE_WS) ? vec_m1(nvec_q) : CW'(row - 1);
                end else begin
                    fl_en = 1'b1;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    inst_nx[BIT_OFIFO_RD] = 1'b1;
                    if (dr_zero) begin
                        state_nx = S_NEXT;
                    end else begin
                        dr_en = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (pass_q == (ntile_q - tile_bw'(1))) begin
                    state_nx = S_DONE;
                end else begin
                    pass_nx = pass_q + tile_bw'(1);
                    ke_load = 1'b1;
                    if (mode_q == MODE_WS) begin
                        state_nx = S_KLOAD;
                        ke_val   = CW'(col - 1);
                    end else begin
                        state_nx = S_EXEC;
                        ke_val   = vec_m1(nvec_q);
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Accumulate trails each OFIFO read by one cycle, even into NEXT.
        inst_nx[BIT_L0_WR]   = 1'b0;
        inst_nx[BIT_SFP_ACC] = inst[BIT_OFIFO_RD];
        busy_nx              = (state_nx != S_IDLE);
        done_nx              = (state_nx == S_DONE);
        inst_nx[BIT_MODE]    = busy_nx & mode_nx;

        // Abort overrides every transition and leaves latched job state untouched.
        if (abort) begin
            state_nx = S_IDLE;
            mode_nx  = mode_q;
            ntile_nx = ntile_q;
            nvec_nx  = nvec_q;
            pass_nx  = '0;
            inst_nx  = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            err_nx   = 1'b0;
            ke_load  = 1'b0;
            ke_en    = 1'b0;
            fl_load  = 1'b0;
            fl_en    = 1'b0;
            dr_load  = 1'b0;
            dr_en    = 1'b0;
        end
    end

    // State, latched job parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            mode_q  <= 1'b0;
            ntile_q <= '0;
            nvec_q  <= '0;
            pass_q  <= '0;
            inst    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            mode_q  <= mode_nx;
            ntile_q <= ntile_nx;
            nvec_q  <= nvec_nx;
            pass_q  <= pass_nx;
            inst    <= inst_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

    assign pass_idx = pass_q;

endmodule

// File: tb/tb_corelet_seq.sv
// Self-checking bench for corelet_seq: directed job scenarios plus randomized handshakes.
// Latency: outputs sampled #1 after the rising edge and by a negedge monitor.
// Backpressure: l0_ready/ofifo_valid randomized in the random phase.
module tb_corelet_seq;
    import corelet_seq_pkg::*;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int TBW = 5;
    localparam int VBW = 8;

    localparam logic [INST_W-1:0] ALLOWED =
        (INST_W'(1) << BIT_KLOAD) | (INST_W'(1) << BIT_EXEC) | (INST_W'(1) << BIT_L0_RD) |
        (INST_W'(1) << BIT_OFIFO_RD) | (INST_W'(1) << BIT_SFP_ACC) | (INST_W'(1) << BIT_MODE);

    logic              clk = 1'b0;
    logic              reset, start, mode, abort, l0_ready, ofifo_valid;
    logic [TBW-1:0]    n_tile;
    logic [VBW-1:0]    n_vec;
    logic [INST_W-1:0] inst;
    logic              busy, done, err;
    logic [TBW-1:0]    pass_idx;

    corelet_seq #(.row(ROW), .col(COL), .tile_bw(TBW), .vec_bw(VBW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .n_tile      (n_tile),
        .n_vec       (n_vec),
        .abort       (abort),
        .l0_ready    (l0_ready),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pass_idx    (pass_idx)
    );

    always #5 clk = ~clk;

    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    // Monitor tallies: 0 kload, 1 exec, 2 reads, 3 acc, 4 done, 5 err, 6 busy cycles, 7 pass steps
    int   mon[8] = '{default: 0};
    int   base[8];
    int   viol   = 0;
    bit   rnd_on = 1'b0;
    logic exp_mode = 1'b0;

    logic           p_l0 = 1'b0, p_ofv = 1'b0, p_rd = 1'b0, p_abort = 1'b0, p_rstn = 1'b0;
    logic [TBW-1:0] p_pass = '0;

    // Per-cycle protocol rules derived from the interface description
    wire c_mask = |(inst & ~ALLOWED);
    wire c_mode = (inst[BIT_MODE] !== (busy ? exp_mode : 1'b0));
    wire c_l0   = (inst[BIT_KLOAD] | inst[BIT_EXEC]) & ~p_l0;
    wire c_rd3  = (inst[BIT_L0_RD] !== (inst[BIT_KLOAD] | inst[BIT_EXEC]));
    wire c_ofv  = inst[BIT_OFIFO_RD] & ~p_ofv;
    wire c_acc  = p_rstn & ~p_abort & (inst[BIT_SFP_ACC] !== p_rd);
    wire c_err  = err & ~done;
    wire c_pass = (pass_idx != p_pass) && (pass_idx != p_pass + TBW'(1)) && (pass_idx != '0);

    // Negedge monitor: tallies commands and counts rule violations.
    always @(negedge clk) begin
        mon[0] <= mon[0] + int'(inst[BIT_KLOAD]);
        mon[1] <= mon[1] + int'(inst[BIT_EXEC]);
        mon[2] <= mon[2] + int'(inst[BIT_OFIFO_RD]);
        mon[3] <= mon[3] + int'(inst[BIT_SFP_ACC]);
        mon[4] <= mon[4] + int'(done);
        mon[5] <= mon[5] + int'(err);
        mon[6] <= mon[6] + int'(busy);
        mon[7] <= mon[7] + int'(pass_idx == p_pass + TBW'(1));
        viol   <= viol + int'(c_mask) + int'(c_mode) + int'(c_l0) + int'(c_rd3)
                       + int'(c_ofv) + int'(c_acc) + int'(c_err) + int'(c_pass);
        p_l0    <= l0_ready;
        p_ofv   <= ofifo_valid;
        p_rd    <= inst[BIT_OFIFO_RD];
        p_abort <= abort;
        p_rstn  <= reset;
        p_pass  <= pass_idx;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_on) begin
            l0_ready    = ($urandom_range(0, 3) != 0);
            ofifo_valid = ($urandom_range(0, 3) != 0);
            start       = busy && ($urandom_range(0, 7) == 0);
            mode        = 1'($urandom);
            n_vec       = VBW'($urandom);
            n_tile      = TBW'($urandom);
        end
    endtask

    task automatic launch(input logic m, input int nt, input int nv);
        mode     = m;
        n_tile   = TBW'(nt);
        n_vec    = VBW'(nv);
        exp_mode = m;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic finish_job(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    // Reference model: per-pass phase lengths straight from the job rules
    function automatic int job_cycles(input logic m, input int nt, input int nv);
        int per;
        if (nt == 0 || nv == 0) return 1;
        per = ((m == MODE_WS) ? COL : 0) + nv + (ROW + COL - 1) + ((m == MODE_WS) ? nv : ROW) + 1;
        return per * nt + 1;
    endfunction

    task automatic chk_job(input string tag, input logic m, input int nt, input int nv);
        bit z;
        z = (nt == 0 || nv == 0);
        chk({tag, " kload"}, mon[0] - base[0], (z || m == MODE_OS) ? 0 : COL * nt);
        chk({tag, " exec"},  mon[1] - base[1], z ? 0 : nv * nt);
        chk({tag, " reads"}, mon[2] - base[2], z ? 0 : ((m == MODE_WS) ? nv : ROW) * nt);
        chk({tag, " acc"},   mon[3] - base[3], z ? 0 : ((m == MODE_WS) ? nv : ROW) * nt);
        chk({tag, " done"},  mon[4] - base[4], 1);
        chk({tag, " err"},   mon[5] - base[5], z ? 1 : 0);
        chk({tag, " pass_steps"}, mon[7] - base[7], z ? 0 : nt - 1);
        chk({tag, " rule_viol"}, viol, 0);
    endtask

    task automatic run_job(input string tag, input logic m, input int nt, input int nv, input bit exact);
        bit got;
        base = mon;
        launch(m, nt, nv);
        finish_job(3000, got);
        chk({tag, " done_seen"}, int'(got), 1);
        chk_job(tag, m, nt, nv);
        chk({tag, " idle_after"}, int'(busy), 0);
        if (exact) chk({tag, " busy_cycles"}, mon[6] - base[6], job_cycles(m, nt, nv));
    endtask

    initial begin
        logic [5:0] pat;
        logic [5:0] obs_ex, obs_rd;
        int         r;
        bit         got;

        reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        l0_ready = 1'b0; ofifo_valid = 1'b0; n_tile = '0; n_vec = '0;

        // Reset state
        repeat (3) step();
        chk("reset inst", int'(inst != '0), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset pass_idx", int'(pass_idx), 0);
        reset = 1'b1;
        step();

        // Directed jobs with free-flowing handshakes
        l0_ready = 1'b1; ofifo_valid = 1'b1;
        run_job("ws_basic", MODE_WS, 1, 4, 1'b1);
        run_job("os_3pass", MODE_OS, 3, 2, 1'b1);
        run_job("zero_vec", MODE_WS, 2, 0, 1'b1);
        run_job("zero_tile", MODE_OS, 0, 5, 1'b1);
        run_job("max_vec", MODE_WS, 1, 255, 1'b1);

        // EXEC stall pattern 1,0,0,1,1,1 on an OS job
        pat = 6'b111001;
        base = mon;
        launch(MODE_OS, 1, 4);
        for (int i = 0; i < 6; i++) begin
            l0_ready = pat[i];
            step();
            obs_ex[i] = inst[BIT_EXEC];
            obs_rd[i] = inst[BIT_L0_RD];
        end
        l0_ready = 1'b1;
        finish_job(3000, got);
        chk("stall exec_pattern", int'(obs_ex), int'(pat));
        chk("stall l0rd_pattern", int'(obs_rd), int'(pat));
        chk("stall done_seen", int'(got), 1);
        chk_job("stall", MODE_OS, 1, 4);

        // Abort in DRAIN after two reads
        base = mon;
        launch(MODE_WS, 1, 6);
        r = 0;
        for (int i = 0; i < 200 && r < 2; i++) begin
            step();
            if (inst[BIT_OFIFO_RD]) r++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort inst", int'(inst != '0), 0);
        chk("abort busy", int'(busy), 0);
        repeat (5) step();
        chk("abort reads", mon[2] - base[2], 2);
        chk("abort no_done", mon[4] - base[4], 0);
        chk("abort rule_viol", viol, 0);
        run_job("post_abort", MODE_WS, 2, 3, 1'b1);

        // Abort and start in the same IDLE cycle
        base = mon;
        mode = MODE_WS; n_tile = TBW'(1); n_vec = VBW'(1);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start busy", int'(busy), 0);
        repeat (3) step();
        chk("abort_start no_done", mon[4] - base[4], 0);
        chk("abort_start busy_cycles", mon[6] - base[6], 0);

        // Reset pulse during EXEC, then a start right after release
        launch(MODE_WS, 1, 50);
        for (int i = 0; i < 100 && !inst[BIT_EXEC]; i++) step();
        chk("rst_exec reached", int'(inst[BIT_EXEC]), 1);
        reset = 1'b0;
        step();
        chk("rst_exec inst", int'(inst != '0), 0);
        chk("rst_exec busy", int'(busy), 0);
        chk("rst_exec done", int'(done), 0);
        chk("rst_exec pass_idx", int'(pass_idx), 0);
        reset = 1'b1;
        base = mon;
        launch(MODE_OS, 2, 3);
        chk("rst_restart busy", int'(busy), 1);
        finish_job(3000, got);
        chk("rst_restart done_seen", int'(got), 1);
        chk_job("rst_restart", MODE_OS, 2, 3);

        // Randomized handshakes, ignored starts while busy, random job shapes
        rnd_on = 1'b1;
        for (int j = 0; j < 8; j++) begin
            logic m;
            int   nt, nv;
            m  = 1'($urandom);
            nt = $urandom_range(1, 3);
            nv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 10);
            run_job($sformatf("rand%0d", j), m, nt, nv, 1'b0);
        end
        rnd_on = 1'b0;
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/corelet_seq.md
CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning): row, 8, MAC array rows and L0 width in lanes; col, 8, MAC array columns and OFIFO width in lanes; tile_bw, 5, width of the pass count; vec_bw, 8, width of the vector count.
REQ-002 Ports, one per line (name, direction, width, meaning): clk, in, 1, single clock, rising edge; reset, in, 1, synchronous reset, active low.
REQ-003 start, in, 1: one-cycle job request; sampled only in IDLE.
REQ-004 mode, in, 1: 0 = weight-stationary (WS), 1 = output-stationary (OS); latched at start.
REQ-005 n_tile, in, tile_bw: accumulation passes per job; latched at start.
REQ-006 n_vec, in, vec_bw: activation vectors per pass; latched at start.
REQ-007 abort, in, 1: forces IDLE on the next edge.
REQ-008 l0_ready, in, 1: L0 not empty.
REQ-009 ofifo_valid, in, 1: OFIFO holds a full row.
REQ-010 inst, out, 35: corelet instruction bus; bit0 = kernel load, bit1 = execute, bit2 = l0_wr (always 0), bit3 = l0_rd, bit6 = ofifo_rd, bit33 = sfp_acc, bit34 = mode; all other bits are 0.
REQ-011 busy, out, 1: high in every state except IDLE.
REQ-012 done, out, 1: one-cycle completion pulse.
REQ-013 err, out, 1: one-cycle pulse marking a zero-length job.
REQ-014 pass_idx, out, tile_bw: index of the current pass.

Function
REQ-015 States: IDLE, KLOAD, EXEC, FLUSH, DRAIN, NEXT, DONE; the state register is the only source of control, and all outputs are registered.
REQ-016 IDLE: start=1 with n_tile!=0 and n_vec!=0 -> KLOAD if mode=0, else EXEC; latch mode, n_tile and n_vec; pass_idx <= 0.
REQ-017 IDLE: start=1 with n_tile=0 or n_vec=0 -> DONE; err pulses in the same cycle as done.
REQ-018 KLOAD (WS only): assert bit3 and bit0 for exactly col l0_ready-qualified cycles, then -> EXEC.
REQ-019 EXEC: assert bit3 and bit1 for exactly n_vec l0_ready-qualified cycles; a cycle with l0_ready=0 is a stall: bits 3/1/0 are low and the counter holds.
REQ-020 FLUSH: all command bits low for row+col-1 cycles (array pipeline drain), then -> DRAIN.
REQ-021 DRAIN: assert bit6 in each cycle where ofifo_valid=1; bit33 asserts exactly one cycle after each read; after R reads (R = n_vec in WS, R = row in OS) -> NEXT, with bit33 for the last read still issued.
REQ-022 NEXT (1 cycle): if pass_idx = n_tile-1 -> DONE; else pass_idx increments and the next state is KLOAD (WS) or EXEC (OS).
REQ-023 DONE (1 cycle): done=1, then -> IDLE.
REQ-024 bit34 equals the latched mode whenever busy=1, else 0.
REQ-025 start while busy=1 is ignored with no side effects.
REQ-026 abort has priority over every transition; it takes effect on the next edge, clears all outputs, and produces no done.
REQ-027 abort and start in the same IDLE cycle: abort wins and the job is not accepted.
REQ-028 Counters never wrap: the vector counter is vec_bw+1 bits; a job with n_vec=2^vec_bw-1 completes.

Reset
REQ-029 reset=0 at a rising edge: state = IDLE, all counters 0, inst = 0, busy = done = err = 0, pass_idx = 0.
REQ-030 Reset mid-job behaves identically to abort; latched job parameters are discarded.

Structure
REQ-031 A shared package holds the state enum, the inst bit-position constants and the mode encoding; the corelet and its test bench import the same package.
REQ-032 One sub-module, seq_cnt: loadable down-counter with an enable and a zero flag, instantiated for the KLOAD/EXEC, FLUSH and DRAIN counts.

Verification
REQ-033 WS, row=col=8, n_tile=1, n_vec=4, l0_ready=1, ofifo_valid=1 -> 8 KLOAD cycles, 4 EXEC cycles, 15 FLUSH cycles, 4 reads, 4 acc pulses, done exactly once, busy low afterwards.
REQ-034 OS, n_tile=3, n_vec=2 -> no bit0 ever asserted, 8 reads per pass, pass_idx steps 0→1→2, a single done.
REQ-035 EXEC with l0_ready toggling 1,0,0,1,1,1 and n_vec=4 -> exactly 4 execute cycles; no bit1 or bit3 during the zero cycles.
REQ-036 start with n_vec=0 -> done and err pulse in the same cycle and no command bits are issued.
REQ-037 abort in DRAIN after 2 reads -> IDLE next cycle, inst=0, no done; a following start runs a full clean job.
REQ-038 reset=0 asserted during EXEC for 1 cycle -> all outputs 0 at the next edge; start in the cycle after reset releases is accepted.
